// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core-side memory bus bridges: FSM states,
// access-size encodings and the alignment rule.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 has no legal encoding, so it is reported through the same path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter that flags when an outstanding bus access has
// been waiting LIMIT cycles.
module bus_timeout_ctr #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count >= LIMIT_W);

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the core memory stage to the external data-memory bus:
// one access per request, registered outputs, single-cycle done/err pulse.
module dmem_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_strb,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_err,
  output logic              mem_busy,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic [1:0]        dbg_state
);

  // Request channel: a transfer happens on any cycle with bus_valid && bus_ready;
  // while bus_valid is high, bus_we/bus_addr/bus_wdata/bus_wstrb do not change.
  // Read channel: bus_rdata is taken on bus_rvalid only while awaiting a response.

  bridge_state_t state, state_next;
  logic          err_q, err_d;
  logic          misaligned;
  logic          expired;
  logic          in_flight;
  logic          load_req;
  logic          capture_rd;
  logic          valid_d, done_d, mem_err_d, busy_d;

  assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
  assign in_flight  = (state == ST_REQ) || (state == ST_RESP);
  assign dbg_state  = state;

  bus_timeout_ctr #(
    .WIDTH (16),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_flight),
    .enable  (in_flight),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout outranks a same-cycle handshake or response so the abort point is fixed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mem_req) state_next = misaligned ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (expired)                     state_next = ST_DONE;
        else if (bus_valid && bus_ready) state_next = bus_we ? ST_DONE : ST_RESP;
      end
      ST_RESP: begin
        if (expired || bus_rvalid) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered.
  always_comb begin
    err_d      = err_q;
    load_req   = (state == ST_IDLE) && mem_req;
    capture_rd = (state == ST_RESP) && bus_rvalid && !expired;
    if (load_req) begin
      err_d = misaligned;
    end else if (in_flight && expired) begin
      err_d = 1'b1;
    end
    valid_d   = (state_next == ST_REQ);
    done_d    = (state_next == ST_DONE);
    mem_err_d = done_d && err_d;
    busy_d    = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      mem_busy  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      err_q     <= err_d;
      bus_valid <= valid_d;
      mem_done  <= done_d;
      mem_err   <= mem_err_d;
      mem_busy  <= busy_d;
      if (load_req) begin
        bus_we    <= mem_we;
        bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
        bus_wdata <= mem_wdata;
        bus_wstrb <= mem_we ? mem_strb : 4'b0000;
      end
      if (capture_rd) begin
        mem_rdata <= bus_rdata;
      end
    end
  end

endmodule
